// File: rtl/ps_regfile_if.sv
// Register-file access channel: a write with a one-deep response path, and a read
// request with a queued response path. All channels use valid/ready handshakes.
interface ps_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  bready;
  logic [DATA_WIDTH-1:0] bdata;
  logic                  bvalid;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  arvalid;
  logic                  aready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  waddr, wdata, wvalid, bready, raddr, arvalid, rready,
    output wready, bdata, bvalid, aready, rdata, rvalid
  );

  modport master (
    output waddr, wdata, wvalid, bready, raddr, arvalid, rready,
    input  wready, bdata, bvalid, aready, rdata, rvalid
  );
endinterface

// File: rtl/ps_regfile.sv
// Register file on a ps_if slave: one outstanding write response (1-cycle latency),
// reads pushed through a RD_DEPTH-entry response FIFO; ready drops when a path is full.
module ps_regfile #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 32,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [DATA_WIDTH-1:0] OOR_DATA   = '1,
  parameter int                    RD_DEPTH   = 2
) (
  input  logic clk,
  input  logic rst,
  ps_if.slave  s
);

  localparam int               PTR_W    = $clog2(RD_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(RD_DEPTH);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_wr_acc;
  logic                  w_wr_hit;
  logic                  w_wr_ro;
  logic [DATA_WIDTH-1:0] w_wr_cur;
  logic [DATA_WIDTH-1:0] w_bresp;

  logic                  w_rd_acc;
  logic                  w_rd_pop;
  logic [DATA_WIDTH-1:0] w_rd_val;

  logic                  r_bvalid;
  logic [DATA_WIDTH-1:0] r_bdata;

  logic [DATA_WIDTH-1:0] r_mem [RD_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  assign w_wr_acc = s.wvalid && s.wready;
  assign w_rd_acc = s.arvalid && s.aready;
  assign w_rd_pop = s.rvalid && s.rready;

  // Address decode by match, so an address outside the implemented range simply
  // hits nothing and falls through to OOR_DATA.
  always_comb begin
    w_wr_hit = 1'b0;
    w_wr_ro  = 1'b0;
    w_wr_cur = OOR_DATA;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (s.waddr == ADDR_WIDTH'(i)) begin
        w_wr_hit = 1'b1;
        w_wr_ro  = RO_MASK[i];
        w_wr_cur = r_regs[i];
      end
    end
  end

  always_comb begin
    w_rd_val = OOR_DATA;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (s.raddr == ADDR_WIDTH'(i)) begin
        w_rd_val = r_regs[i];
      end
    end
  end

  // Response carries the value the register holds after this write.
  assign w_bresp = !w_wr_hit ? OOR_DATA : (w_wr_ro ? w_wr_cur : s.wdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_wr_acc && w_wr_hit && !w_wr_ro) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (s.waddr == ADDR_WIDTH'(i)) begin
          r_regs[i] <= s.wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bdata  <= '0;
    end else if (w_wr_acc) begin
      r_bvalid <= 1'b1;
      r_bdata  <= w_bresp;
    end else if (s.bready) begin
      r_bvalid <= 1'b0;
    end
  end

  assign s.wready = !r_bvalid && !rst;
  assign s.bvalid = r_bvalid;
  assign s.bdata  = r_bdata;

  // Storage needs no reset: nothing is visible until r_count says so.
  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_mem[r_wptr] <= w_rd_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_rd_acc) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_rd_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_rd_acc, w_rd_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // aready looks only at the current count, so a full FIFO refuses a push even on a pop edge.
  assign s.aready = (r_count < LP_DEPTH) && !rst;
  assign s.rvalid = (r_count != '0);
  assign s.rdata  = s.rvalid ? r_mem[r_rptr] : '0;

endmodule

// File: tb/tb_ps_regfile.sv
// Bench for ps_regfile: 8 registers, register 2 read-only, 2-deep read FIFO.
module tb_ps_regfile;

  localparam logic [31:0] RV  = 32'h0000_5A5A;
  localparam logic [31:0] OOR = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  ps_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  ps_regfile #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .NUM_REGS  (8),
    .RO_MASK   (8'b0000_0100),
    .RESET_VAL (RV),
    .OOR_DATA  (OOR),
    .RD_DEPTH  (2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .s  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: reference register model updated at every accepted handshake.
  logic [31:0] m_regs [8];
  logic [31:0] q_b [$];
  logic [31:0] q_r [$];

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a < 5'd8) ? m_regs[a[2:0]] : OOR;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q_b.delete();
      q_r.delete();
      for (int i = 0; i < 8; i++) m_regs[i] = RV;
    end else begin
      if (bus.bvalid && bus.bready) begin
        if (q_b.size() == 0) chk("sb_b_pending", q_b.size(), 1);
        else chk("sb_bdata", bus.bdata, q_b.pop_front());
      end
      if (bus.rvalid && bus.rready) begin
        if (q_r.size() == 0) chk("sb_r_pending", q_r.size(), 1);
        else chk("sb_rdata", bus.rdata, q_r.pop_front());
      end
      if (bus.arvalid && bus.aready) q_r.push_back(m_read(bus.raddr));
      if (bus.wvalid && bus.wready) begin
        if (bus.waddr < 5'd8 && bus.waddr != 5'd2) m_regs[bus.waddr[2:0]] = bus.wdata;
        q_b.push_back(m_read(bus.waddr));
      end
    end
  end

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.waddr = a; bus.wdata = d; bus.wvalid = 1'b1; bus.bready = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.wready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    if (!ok) chk("wr_accept_timeout", 32'(ok), 1);
    @(negedge clk);
    chk("wr_bvalid_lat1", 32'(bus.bvalid), 1);
    chk("wr_bdata", bus.bdata, exp);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.raddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.aready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    if (!ok) chk("rd_accept_timeout", 32'(ok), 1);
    @(negedge clk);
    chk("rd_rvalid_lat1", 32'(bus.rvalid), 1);
    chk("rd_rdata", bus.rdata, exp);
  endtask

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    n_chk = 0;
    n_err = 0;
    tbl[0]  = '{1'b1, 5'd3,  32'hA5A5_0001, 32'hA5A5_0001};
    tbl[1]  = '{1'b0, 5'd3,  32'h0,         32'hA5A5_0001};
    tbl[2]  = '{1'b1, 5'd2,  32'h0000_1234, RV};
    tbl[3]  = '{1'b0, 5'd2,  32'h0,         RV};
    tbl[4]  = '{1'b1, 5'd9,  32'hDEAD_BEEF, OOR};
    tbl[5]  = '{1'b0, 5'd9,  32'h0,         OOR};
    tbl[6]  = '{1'b0, 5'd1,  32'h0,         RV};
    tbl[7]  = '{1'b1, 5'd1,  32'h0101_0101, 32'h0101_0101};
    tbl[8]  = '{1'b1, 5'd7,  32'h0000_0007, 32'h0000_0007};
    tbl[9]  = '{1'b0, 5'd7,  32'h0,         32'h0000_0007};
    tbl[10] = '{1'b1, 5'd0,  32'hFFFF_0000, 32'hFFFF_0000};
    tbl[11] = '{1'b0, 5'd0,  32'h0,         32'hFFFF_0000};
    tbl[12] = '{1'b0, 5'd31, 32'h0,         OOR};
    tbl[13] = '{1'b1, 5'd5,  32'h0000_0011, 32'h0000_0011};
    tbl[14] = '{1'b0, 5'd5,  32'h0,         32'h0000_0011};
    tbl[15] = '{1'b0, 5'd1,  32'h0,         32'h0101_0101};

    rst = 1'b1;
    bus.waddr = '0; bus.wdata = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.raddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    #3;
    chk("rst_wready", 32'(bus.wready), 0);
    chk("rst_aready", 32'(bus.aready), 0);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_bdata",  bus.bdata, 0);
    chk("rst_rdata",  bus.rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].exp);
      else           do_read(tbl[i].addr, tbl[i].exp);
    end

    // Same-edge write and read of register 5 (holds 0x11).
    @(posedge clk); #1;
    bus.waddr = 5'd5; bus.wdata = 32'h77; bus.wvalid = 1'b1;
    bus.raddr = 5'd5; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("same_wready", 32'(bus.wready), 1);
    chk("same_aready", 32'(bus.aready), 1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk);
    chk("same_rdata_old", bus.rdata, 32'h11);
    chk("same_bdata_new", bus.bdata, 32'h77);
    do_read(5'd5, 32'h77);

    // Fill the read FIFO with rready low, then drain in order.
    @(posedge clk); #1;
    bus.rready = 1'b0; bus.raddr = 5'd0; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("fifo_aready0", 32'(bus.aready), 1);
    @(posedge clk); #1;
    bus.raddr = 5'd1;
    @(negedge clk);
    chk("fifo_aready1", 32'(bus.aready), 1);
    @(posedge clk); #1;
    bus.raddr = 5'd2;
    @(negedge clk);
    chk("fifo_full_aready", 32'(bus.aready), 0);
    chk("fifo_full_rdata", bus.rdata, 32'hFFFF_0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fifo_hold_rdata", bus.rdata, 32'hFFFF_0000);
    chk("fifo_hold_rvalid", 32'(bus.rvalid), 1);
    @(posedge clk); #1;
    bus.rready = 1'b1;
    @(negedge clk);
    chk("fifo_pop_full_aready", 32'(bus.aready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fifo_second_rdata", bus.rdata, 32'h0101_0101);
    chk("fifo_after_pop_aready", 32'(bus.aready), 1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    chk("fifo_third_rdata", bus.rdata, RV);
    chk("fifo_third_rvalid", 32'(bus.rvalid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fifo_empty_rvalid", 32'(bus.rvalid), 0);

    // Reset with a held write response and two queued reads.
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.waddr = 5'd4; bus.wdata = 32'h44; bus.wvalid = 1'b1;
    @(negedge clk);
    chk("rstseq_wready", 32'(bus.wready), 1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.raddr = 5'd4; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.raddr = 5'd3;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    chk("rstseq_bvalid", 32'(bus.bvalid), 1);
    chk("rstseq_bdata", bus.bdata, 32'h44);
    chk("rstseq_rdata", bus.rdata, 32'h44);
    chk("rstseq_full", 32'(bus.aready), 0);
    @(negedge clk);
    chk("rstseq_bdata_stable", bus.bdata, 32'h44);
    rst = 1'b1;
    #1;
    chk("async_bvalid", 32'(bus.bvalid), 0);
    chk("async_rvalid", 32'(bus.rvalid), 0);
    chk("async_wready", 32'(bus.wready), 0);
    chk("async_aready", 32'(bus.aready), 0);
    chk("async_rdata", bus.rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_aready", 32'(bus.aready), 1);
    for (int i = 0; i < 8; i++) do_read(5'(i), RV);

    @(negedge clk);
    chk("sb_b_drained", q_b.size(), 0);
    chk("sb_r_drained", q_r.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps_regfile.md
PS_REGFILE -- requirements
Module: ps_regfile

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, address width of all ps channels.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all ps channels and registers.
REQ-003 Parameter NUM_REGS, default 32, number of implemented registers; 1 <= NUM_REGS <= 2**ADDR_WIDTH.
REQ-004 Parameter RO_MASK, default 0 (NUM_REGS bits), bit i = 1 makes register i read-only.
REQ-005 Parameter RESET_VAL, default 0 (DATA_WIDTH bits), reset value of every register.
REQ-006 Parameter OOR_DATA, default all-ones (DATA_WIDTH bits), value returned for out-of-range addresses.
REQ-007 Parameter RD_DEPTH, default 2, read-response FIFO depth, power of two, >= 2.
REQ-008 Port clk input 1, single clock, all state on rising edge.
REQ-009 Port rst input 1, reset, asynchronous, active-high.
REQ-010 Port s input ps_if.slave (ADDR_WIDTH, DATA_WIDTH), carries waddr/wdata/wvalid/wready, bready/bdata/bvalid, raddr/arvalid/aready, rdata/rvalid/rready.

Function
REQ-011 Write accept occurs on a rising edge with wvalid=1 and wready=1.
REQ-012 wready SHALL equal !bvalid and !rst: at most one outstanding write response.
REQ-013 On accept with waddr < NUM_REGS and RO_MASK[waddr]=0, register[waddr] SHALL take wdata at that edge.
REQ-014 On accept to a read-only or out-of-range address, no register SHALL change.
REQ-015 bvalid SHALL rise on the edge after accept (1-cycle latency) and hold until the edge where bvalid=1 and bready=1.
REQ-016 bdata SHALL be the post-write content of the addressed register, or OOR_DATA if out of range, and stay stable while bvalid=1.
REQ-017 A new write SHALL be accepted on the same edge that bready retires the previous response only if wready was 1 (it is not: wready is low while bvalid=1; back-to-back writes take 2 cycles each).
REQ-018 Read accept occurs on a rising edge with arvalid=1 and aready=1; aready SHALL equal (fifo count < RD_DEPTH) and !rst.
REQ-019 On read accept, the register value sampled before any same-edge write (or OOR_DATA if raddr >= NUM_REGS) SHALL be pushed into the read FIFO.
REQ-020 rvalid SHALL equal (fifo count > 0); rdata SHALL be the FIFO head; read latency from accept to rvalid is 1 cycle when the FIFO was empty.
REQ-021 Pop occurs on an edge with rvalid=1 and rready=1; rdata/rvalid SHALL be held stable while rvalid=1 and rready=0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order; push is never accepted while count = RD_DEPTH even if a pop occurs on that edge.
REQ-023 FIFO pointers SHALL wrap modulo RD_DEPTH; count SHALL be log2(RD_DEPTH)+1 bits and never exceed RD_DEPTH.
REQ-024 Read and write channels SHALL operate independently; a same-edge read and write to the same address SHALL return the old value.
REQ-025 Responses SHALL be returned in acceptance order; no reordering, no data loss under any valid/ready pattern.

Reset
REQ-026 While rst=1: all registers = RESET_VAL, bvalid=0, bdata=0, rvalid=0, rdata=0, FIFO count=0, wready=0, aready=0.
REQ-027 Reset asserted mid-transaction SHALL discard pending write responses and queued read data immediately (asynchronously).
REQ-028 First accept is possible on the first rising edge after rst deasserts.

Verification
REQ-029 Write addr 3 data 0xA5A5_0001, bready=1 -> bvalid one cycle later, bdata=0xA5A5_0001; read addr 3 -> rdata=0xA5A5_0001 one cycle after accept.
REQ-030 RO_MASK bit 2 set, write addr 2 data 0x1234 -> bdata=RESET_VAL; subsequent read addr 2 -> RESET_VAL.
REQ-031 NUM_REGS=8, write then read addr 9 -> bdata=0xFFFF_FFFF, rdata=0xFFFF_FFFF, no register changed.
REQ-032 RD_DEPTH=2, rready=0, arvalid held with addrs 0,1,2 -> aready drops after 2 accepts; raise rready -> data for 0,1 then 2 in order, no loss.
REQ-033 Same edge: write addr 5 = 0x77 and read addr 5 (prior 0x11) -> rdata=0x11; next read -> 0x77.
REQ-034 Assert rst with bvalid=1 and FIFO holding 2 entries -> bvalid, rvalid drop immediately; after release all registers read RESET_VAL.
